lbp_host: RTL and testbench
===========================

// Module: lbp_host
// PURPOSE
//   Memory-side responder for the LBP engine's pixel/result interface. Holds a 128x128 8-bit gray
//   image, answers gray_req reads with registered gray_data, and captures lbp_valid result writes
//   into a result memory. After finish it serves the result image over a readback port.
//   Sits between the image loader (upstream) and the LBP engine (downstream).
// PARAMETERS
//   IMG_DIM  128  image width = height in pixels; address = (row<<7)+col
//   ADDR_W   14   pixel address width (log2(IMG_DIM*IMG_DIM))
//   DATA_W   8    pixel / LBP value width
// PORTS
//   clk         in   1       single clock, all logic on rising edge
//   reset       in   1       asynchronous, active-high
//   load_valid  in   1       image load beat strobe, raster order from address 0
//   load_data   in   DATA_W  pixel value for the current load beat
//   gray_ready  out  1       image fully loaded, pixel reads are served
//   gray_req    in   1       engine pixel read request
//   gray_addr   in   ADDR_W  pixel read address
//   gray_data   out  DATA_W  registered pixel read data
//   lbp_valid   in   1       engine result write strobe
//   lbp_addr    in   ADDR_W  result write address
//   lbp_data    in   DATA_W  result write data
//   finish      in   1       engine completion flag (level)
//   done        out  1       results frozen, readback enabled
//   rd_addr     in   ADDR_W  result readback address
//   rd_data     out  DATA_W  registered result readback data
//   wr_count    out  ADDR_W  number of accepted result writes, saturates at 2^ADDR_W-1
//   proto_err   out  1       sticky protocol-violation flag
// BEHAVIOUR
//   Reset values: gray_ready=0, gray_data=0, done=0, rd_data=0, wr_count=0, proto_err=0,
//   load pointer=0, state=LOAD. Memory arrays are not cleared by reset.
//   FSM states LOAD -> SERVE -> DONE; DONE is left only by reset.
//   LOAD: each cycle with load_valid=1 writes gray_mem[ptr]<=load_data, ptr++. The beat at
//     ptr=IMG_DIM*IMG_DIM-1 moves the FSM to SERVE; gray_ready=1 from the next cycle.
//     gray_req=1, lbp_valid=1 or finish=1 in LOAD sets proto_err and is otherwise ignored.
//   SERVE: gray_ready=1. On a cycle with gray_req=1, gray_data<=gray_mem[gray_addr], visible on
//     the next cycle (1-cycle latency). Back-to-back requests give one new word per cycle.
//     On gray_req=0, gray_data holds its last value. load_valid is ignored.
//   Result write: lbp_valid=1 in SERVE with an interior address (row and col in 1..IMG_DIM-2)
//     writes lbp_mem[lbp_addr]<=lbp_data and increments wr_count. A border address (row or col
//     equal to 0 or IMG_DIM-1) is not written, does not count, and sets proto_err.
//     Repeated writes to the same address overwrite and count each time.
//   finish: first cycle finish=1 is sampled in SERVE, FSM goes to DONE. done=1 and gray_ready=0
//     from the next cycle. An lbp_valid in that same cycle is still written and counted.
//   DONE: every cycle rd_data<=lbp_mem[rd_addr] (1-cycle latency). For a border rd_addr,
//     rd_data<=0 regardless of memory contents. gray_req, lbp_valid and load_valid set
//     proto_err and are otherwise ignored. gray_data holds its value.
//   proto_err clears only on reset. Reset mid-operation returns to LOAD with ptr=0; a new image
//     must be loaded in full before gray_ready rises again.
// TESTING
//   1 Load ramp pixel[a]=a[7:0] for 16384 beats -> gray_ready=0 after beat 16383, =1 the cycle
//     after; gray_req with addr 0x0081 -> gray_data=0x81 on the next cycle.
//   2 Back-to-back gray_req at addrs 0x0000,0x0001,0x0080 -> gray_data 0x00,0x01,0x80 on
//     consecutive cycles; drop gray_req -> gray_data holds 0x80.
//   3 lbp_valid at addr 0x0081 data 0x5A, then finish, rd_addr=0x0081 -> wr_count=1, done=1,
//     rd_data=0x5A; rd_addr=0x0000 -> rd_data=0x00.
//   4 lbp_valid at border addr 0x007F -> proto_err=1, wr_count unchanged, rd_data for 0x007F = 0.
//   5 lbp_valid(0x3F7E, 0xC3) coincident with finish -> write captured, wr_count increments,
//     done=1 the next cycle; a later lbp_valid -> proto_err=1, no write.
//   6 Assert reset at load beat 5000 -> all outputs at reset values; reload 16384 beats ->
//     gray_ready=1, gray_req at 0x0000 returns the new image's pixel 0.

Source files
------------

// File: rtl/lbp_host.sv
// Memory-side responder for the LBP engine: loads a gray image, serves pixel reads,
// captures interior result writes and exposes the result image for readback after finish.
module lbp_host #(
  parameter int IMG_DIM = 128,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [DATA_W-1:0] gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wr_count,
  output logic              proto_err
);
  localparam int COL_W = $clog2(IMG_DIM);
  localparam int ROW_W = ADDR_W - COL_W;
  localparam logic [COL_W-1:0]  COL_MAX = COL_W'(IMG_DIM - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(IMG_DIM - 1);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(IMG_DIM * IMG_DIM - 1);

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [DATA_W-1:0] gray_mem [IMG_DIM*IMG_DIM];
  logic [DATA_W-1:0] lbp_mem  [IMG_DIM*IMG_DIM];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] gray_data_q, gray_data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] wr_count_q, wr_count_d;
  logic              proto_err_q, proto_err_d;
  logic              gray_we, lbp_we;

  // Border pixels have no full 3x3 neighbourhood, so they never hold a result.
  function automatic logic is_interior(input logic [ADDR_W-1:0] a);
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    row = a[ADDR_W-1:COL_W];
    col = a[COL_W-1:0];
    return (row != '0) && (row != ROW_MAX) && (col != '0) && (col != COL_MAX);
  endfunction

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gray_data_d = gray_data_q;
    rd_data_d   = rd_data_q;
    wr_count_d  = wr_count_q;
    proto_err_d = proto_err_q;
    gray_we     = 1'b0;
    lbp_we      = 1'b0;
    case (state_q)
      LOAD: begin
        if (load_valid) begin
          gray_we = 1'b1;
          ptr_d   = ptr_q + 1'b1;
          if (ptr_q == LAST) state_d = SERVE;
        end
        if (gray_req || lbp_valid || finish) proto_err_d = 1'b1;
      end
      SERVE: begin
        if (gray_req) gray_data_d = gray_mem[gray_addr];
        if (lbp_valid) begin
          if (is_interior(lbp_addr)) begin
            lbp_we = 1'b1;
            if (wr_count_q != '1) wr_count_d = wr_count_q + 1'b1;
          end else begin
            proto_err_d = 1'b1;
          end
        end
        if (finish) state_d = DONE;
      end
      DONE: begin
        rd_data_d = is_interior(rd_addr) ? lbp_mem[rd_addr] : '0;
        if (gray_req || lbp_valid || load_valid) proto_err_d = 1'b1;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      ptr_q       <= '0;
      gray_data_q <= '0;
      rd_data_q   <= '0;
      wr_count_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gray_data_q <= gray_data_d;
      rd_data_q   <= rd_data_d;
      wr_count_q  <= wr_count_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Arrays are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (gray_we) gray_mem[ptr_q]   <= load_data;
    if (lbp_we)  lbp_mem[lbp_addr] <= lbp_data;
  end

  assign gray_ready = (state_q == SERVE);
  assign done       = (state_q == DONE);
  assign gray_data  = gray_data_q;
  assign rd_data    = rd_data_q;
  assign wr_count   = wr_count_q;
  assign proto_err  = proto_err_q;
endmodule

// File: tb/tb_lbp_host.sv
// Directed bench for lbp_host: read results are queued at request time and popped when due.
module tb_lbp_host;
  localparam int N = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        gray_ready;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic [7:0]  gray_data;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        done;
  logic [13:0] rd_addr;
  logic [7:0]  rd_data;
  logic [13:0] wr_count;
  logic        proto_err;

  int checks = 0;
  int failures = 0;
  logic [7:0] gq[$];
  logic [7:0] rq[$];

  lbp_host dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .gray_ready(gray_ready), .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish),
    .done(done), .rd_addr(rd_addr), .rd_data(rd_data), .wr_count(wr_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_gray(input string tag);
    logic [7:0] e;
    if (gq.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s observed=empty expected=queued", tag);
    end else begin
      e = gq.pop_front();
      chk(tag, 16'(gray_data), 16'(e));
    end
  endtask

  task automatic pop_rd(input string tag);
    logic [7:0] e;
    if (rq.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s observed=empty expected=queued", tag);
    end else begin
      e = rq.pop_front();
      chk(tag, 16'(rd_data), 16'(e));
    end
  endtask

  function automatic logic [7:0] img_a(input int a);
    return 8'(a);
  endfunction

  function automatic logic [7:0] img_b(input int a);
    return 8'(a) ^ 8'h3C;
  endfunction

  task automatic load_image(input bit second);
    for (int i = 0; i < N; i++) begin
      load_valid = 1'b1;
      load_data  = second ? img_b(i) : img_a(i);
      if (i == N - 1) chk("ready_low_last_beat", 16'(gray_ready), 16'd0);
      step();
    end
    load_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 16'(gray_ready), 16'd0);
    chk({tag, "_gdata"}, 16'(gray_data),  16'd0);
    chk({tag, "_done"},  16'(done),       16'd0);
    chk({tag, "_rdata"}, 16'(rd_data),    16'd0);
    chk({tag, "_wrcnt"}, 16'(wr_count),   16'd0);
    chk({tag, "_perr"},  16'(proto_err),  16'd0);
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = '0; gray_req = 1'b0; gray_addr = '0;
    lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0; finish = 1'b0; rd_addr = '0;
    step();
    chk_reset_vals("por");
    reset = 1'b0;
    step();

    // Image A: ramp
    load_image(1'b0);
    chk("ready_after_load", 16'(gray_ready), 16'd1);
    chk("perr_after_load", 16'(proto_err), 16'd0);

    gray_req = 1'b1; gray_addr = 14'h0081; gq.push_back(img_a(14'h0081));
    step(); gray_req = 1'b0;
    pop_gray("gread_0081");

    gray_req = 1'b1; gray_addr = 14'h0000; gq.push_back(img_a(0));
    step(); pop_gray("b2b_0000");
    gray_addr = 14'h0001; gq.push_back(img_a(1));
    step(); pop_gray("b2b_0001");
    gray_addr = 14'h0080; gq.push_back(img_a(14'h0080));
    step(); pop_gray("b2b_0080");
    gray_req = 1'b0; gray_addr = 14'h0005;
    step(); chk("gdata_hold1", 16'(gray_data), 16'h0080);
    step(); chk("gdata_hold2", 16'(gray_data), 16'h0080);

    lbp_valid = 1'b1; lbp_addr = 14'h0081; lbp_data = 8'h5A;
    step(); lbp_valid = 1'b0;
    chk("wrcnt_1", 16'(wr_count), 16'd1);
    chk("perr_interior", 16'(proto_err), 16'd0);

    lbp_valid = 1'b1; lbp_addr = 14'h3F7E; lbp_data = 8'hC3; finish = 1'b1;
    chk("done_before_finish", 16'(done), 16'd0);
    step(); lbp_valid = 1'b0; finish = 1'b0;
    chk("done_set", 16'(done), 16'd1);
    chk("ready_drop", 16'(gray_ready), 16'd0);
    chk("wrcnt_finish_cycle", 16'(wr_count), 16'd2);
    chk("perr_finish", 16'(proto_err), 16'd0);

    rd_addr = 14'h0081; rq.push_back(8'h5A); step(); pop_rd("rd_0081");
    rd_addr = 14'h0000; rq.push_back(8'h00); step(); pop_rd("rd_0000");
    rd_addr = 14'h3F7E; rq.push_back(8'hC3); step(); pop_rd("rd_3f7e");

    lbp_valid = 1'b1; lbp_addr = 14'h0081; lbp_data = 8'hFF;
    step(); lbp_valid = 1'b0;
    chk("perr_lbp_in_done", 16'(proto_err), 16'd1);
    chk("wrcnt_frozen", 16'(wr_count), 16'd2);
    chk("gdata_hold_done", 16'(gray_data), 16'h0080);
    rd_addr = 14'h0081; rq.push_back(8'h5A); step(); pop_rd("rd_0081_nowrite");

    // Reset in the middle of a new load, then load image B
    for (int i = 0; i < 5000; i++) begin
      load_valid = 1'b1; load_data = img_b(i); step();
    end
    reset = 1'b1; load_valid = 1'b0;
    #2;
    chk_reset_vals("midrst");
    step(); reset = 1'b0; step();
    load_image(1'b1);
    chk("ready_reload", 16'(gray_ready), 16'd1);

    gray_req = 1'b1; gray_addr = 14'h0000; gq.push_back(img_b(0));
    step(); gray_req = 1'b0;
    pop_gray("reload_px0");
    gray_req = 1'b1; gray_addr = 14'h2A55; gq.push_back(img_b(14'h2A55));
    step(); gray_req = 1'b0;
    pop_gray("reload_px2a55");

    lbp_valid = 1'b1; lbp_addr = 14'h007F; lbp_data = 8'h77;
    step(); lbp_valid = 1'b0;
    chk("perr_border", 16'(proto_err), 16'd1);
    chk("wrcnt_border", 16'(wr_count), 16'd0);

    lbp_valid = 1'b1; lbp_addr = 14'h0101; lbp_data = 8'h11; step();
    lbp_data = 8'h22; step(); lbp_valid = 1'b0;
    chk("wrcnt_overwrite", 16'(wr_count), 16'd2);
    finish = 1'b1; step(); finish = 1'b0;
    rd_addr = 14'h007F; rq.push_back(8'h00); step(); pop_rd("rd_border_007f");
    rd_addr = 14'h0101; rq.push_back(8'h22); step(); pop_rd("rd_overwrite");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
